// File: rtl/lb_stream_ctrl.sv
// Line-buffer frame sequencer: accepts a raster stream, writes it through to the buffer and flags
// complete stencil windows one cycle after acceptance; input stalls while the output slot is full.
module lb_stream_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int KW    = 3,
  parameter int KH    = 3,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          start,
  input  logic          in_valid,
  input  logic [15:0]   in_data,
  output logic          in_ready,
  output logic          lb_wen,
  output logic [15:0]   lb_wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          out_last,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(KW - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(KH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          ovld_q, ovld_d;
  logic [RW-1:0] orow_q, orow_d;
  logic [CW-1:0] ocol_q, ocol_d;
  logic          olast_q, olast_d;
  logic          acc;
  logic          at_last;

  // The output slot frees up in the same cycle it is consumed, so a full pipe still moves 1 pixel/cycle.
  assign in_ready   = (state_q == ACTIVE) && (!ovld_q || out_ready);
  assign acc        = in_valid && in_ready;
  assign lb_wen     = acc;
  assign lb_wdata   = in_data;
  assign at_last    = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign frame_done = (state_q == DONE) && (!ovld_q || out_ready);
  assign busy       = (state_q != IDLE);
  assign out_valid  = ovld_q;
  assign out_row    = orow_q;
  assign out_col    = ocol_q;
  assign out_last   = olast_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ovld_d  = ovld_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    olast_d = olast_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACTIVE;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ACTIVE: begin
        if (acc) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) state_d = DONE;
            else                   row_d   = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (frame_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (acc) begin
      ovld_d  = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
      olast_d = at_last;
      orow_d  = row_q;
      ocol_d  = col_q;
    end else if (out_ready) begin
      ovld_d  = 1'b0;
      olast_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ovld_q  <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ovld_q  <= ovld_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      olast_q <= olast_d;
    end
  end

endmodule

// File: tb/tb_lb_stream_ctrl.sv
// Directed bench for lb_stream_ctrl: a 4x3 frame with a 2x2 kernel, plus a 2x2 frame with a 1x1 kernel.
module tb_lb_stream_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET, start, in_valid, out_ready;
  logic [15:0] in_data;
  logic        in_ready, lb_wen, out_valid, out_last, busy, frame_done;
  logic [15:0] lb_wdata;
  logic [1:0]  out_row;
  logic [1:0]  out_col;

  logic        b_start, b_in_valid, b_out_ready;
  logic [15:0] b_in_data;
  logic        b_in_ready, b_lb_wen, b_out_valid, b_out_last, b_busy, b_frame_done;
  logic [15:0] b_lb_wdata;
  logic [0:0]  b_out_row;
  logic [0:0]  b_out_col;

  lb_stream_ctrl #(.IMG_W(4), .IMG_H(3), .KW(2), .KH(2)) u_dut (
    .CLK(CLK), .RESET(RESET), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .lb_wen(lb_wen), .lb_wdata(lb_wdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .frame_done(frame_done)
  );

  lb_stream_ctrl #(.IMG_W(2), .IMG_H(2), .KW(1), .KH(1)) u_dut_k1 (
    .CLK(CLK), .RESET(RESET), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .lb_wen(b_lb_wen), .lb_wdata(b_lb_wdata), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_row(b_out_row), .out_col(b_out_col), .out_last(b_out_last),
    .busy(b_busy), .frame_done(b_frame_done)
  );

  int nvec = 0;
  int nerr = 0;

  int wen_cnt, done_cnt, done_at, last_acc, last_hs, cyc_no;
  int win_r[$];
  int win_c[$];
  int win_l[$];
  bit chk_stall;
  bit stall_seen;
  bit acc_dummy;

  int exp_r[6] = '{1, 1, 1, 2, 2, 2};
  int exp_c[6] = '{1, 2, 3, 1, 2, 3};
  int exp_br[4] = '{0, 0, 1, 1};
  int exp_bc[4] = '{0, 1, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of the 4x3 instance: observe at the falling edge, return just after the rising edge.
  task automatic tick(output bit acc);
    @(negedge CLK);
    acc = in_valid && in_ready;
    if (chk_stall) begin
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_lb_wen", 32'(lb_wen), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_out_row", 32'(out_row), 1);
      chk("stall_out_col", 32'(out_col), 2);
    end
    if (lb_wen) begin
      chk("lb_wdata", 32'(lb_wdata), 32'(wen_cnt));
      wen_cnt++;
      last_acc = cyc_no;
    end
    if (out_valid && out_ready) begin
      win_r.push_back(int'(out_row));
      win_c.push_back(int'(out_col));
      win_l.push_back(int'(out_last));
      if (out_last) last_hs = cyc_no;
    end
    if (frame_done) begin
      done_cnt++;
      done_at = cyc_no;
    end
    @(posedge CLK);
    #1;
    cyc_no++;
  endtask

  task automatic clr();
    wen_cnt = 0; done_cnt = 0; done_at = -100; last_acc = -200; last_hs = -300;
    win_r.delete(); win_c.delete(); win_l.delete();
    stall_seen = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(acc_dummy);
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit bubbles, input bit stall, input int start_at);
    int  sent = 0;
    int  k = 0;
    int  stall_left = 0;
    bit  started = 0;
    bit  acc;
    while (sent < n && k < 300) begin
      start    = (start_at >= 0 && sent == start_at && !started);
      in_valid = bubbles ? (k % 2 == 0) : 1'b1;
      in_data  = 16'(sent);
      if (stall && !stall_seen && out_valid && out_row == 2'd1 && out_col == 2'd2) begin
        stall_seen = 1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      chk_stall = (stall_left != 0);
      tick(acc);
      if (start) started = 1;
      if (acc) sent++;
      if (stall_left > 0) stall_left--;
      k++;
    end
    start = 0; in_valid = 0; out_ready = 1; chk_stall = 0;
    if (sent < n) chk("feed_timeout", 32'(sent), 32'(n));
  endtask

  task automatic drain();
    in_valid = 0;
    out_ready = 1;
    repeat (4) tick(acc_dummy);
  endtask

  task automatic check_frame(input string p);
    chk({p, "_wen_cnt"}, 32'(wen_cnt), 12);
    chk({p, "_win_cnt"}, 32'(win_r.size()), 6);
    for (int i = 0; i < 6 && i < win_r.size(); i++) begin
      chk({p, "_win_row"}, 32'(win_r[i]), 32'(exp_r[i]));
      chk({p, "_win_col"}, 32'(win_c[i]), 32'(exp_c[i]));
      chk({p, "_win_last"}, 32'(win_l[i]), (i == 5) ? 1 : 0);
    end
    chk({p, "_done_cnt"}, 32'(done_cnt), 1);
    chk({p, "_done_lat"}, 32'(done_at - last_acc), 1);
    chk({p, "_done_at_last"}, 32'(done_at), 32'(last_hs));
    chk({p, "_busy_end"}, 32'(busy), 0);
  endtask

  initial begin
    int bw_r[$];
    int bw_c[$];
    int bw_l[$];
    int b_done = 0;
    int b_wen = 0;

    RESET = 1; start = 0; in_valid = 0; in_data = '0; out_ready = 1; chk_stall = 0;
    b_start = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 1;
    cyc_no = 0;
    clr();
    tick(acc_dummy);
    tick(acc_dummy);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_out_row", 32'(out_row), 0);
    chk("rst_out_col", 32'(out_col), 0);
    RESET = 0;

    in_valid = 1;
    #1;
    chk("unarmed_in_ready", 32'(in_ready), 0);
    chk("unarmed_lb_wen", 32'(lb_wen), 0);
    tick(acc_dummy);
    chk("unarmed_busy", 32'(busy), 0);
    in_valid = 0;

    clr(); pulse_start();
    chk("start_busy", 32'(busy), 1);
    feed(12, 0, 0, -1); drain(); check_frame("basic");

    clr(); pulse_start(); feed(12, 0, 1, -1); drain(); check_frame("bp");
    chk("bp_stall_seen", 32'(stall_seen), 1);

    clr(); pulse_start(); feed(12, 1, 0, -1); drain(); check_frame("bubble");

    clr(); pulse_start(); feed(12, 0, 0, 5); drain(); check_frame("restart");

    clr(); pulse_start(); feed(7, 0, 0, -1);
    chk("mid_wen_cnt", 32'(wen_cnt), 7);
    RESET = 1;
    tick(acc_dummy);
    RESET = 0;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_frame_done", 32'(frame_done), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    repeat (3) tick(acc_dummy);
    chk("mid_rst_no_done", 32'(done_cnt), 0);
    clr(); pulse_start(); feed(12, 0, 0, -1); drain(); check_frame("post_rst");

    b_start = 1;
    @(posedge CLK); #1;
    b_start = 0;
    for (int k = 0; k < 8; k++) begin
      b_in_valid = (k < 4);
      b_in_data  = 16'(k);
      @(negedge CLK);
      if (b_lb_wen) b_wen++;
      if (b_out_valid && b_out_ready) begin
        bw_r.push_back(int'(b_out_row));
        bw_c.push_back(int'(b_out_col));
        bw_l.push_back(int'(b_out_last));
      end
      if (b_frame_done) b_done++;
      @(posedge CLK); #1;
    end
    b_in_valid = 0;
    chk("k1_wen_cnt", 32'(b_wen), 4);
    chk("k1_win_cnt", 32'(bw_r.size()), 4);
    for (int i = 0; i < 4 && i < bw_r.size(); i++) begin
      chk("k1_win_row", 32'(bw_r[i]), 32'(exp_br[i]));
      chk("k1_win_col", 32'(bw_c[i]), 32'(exp_bc[i]));
      chk("k1_win_last", 32'(bw_l[i]), (i == 3) ? 1 : 0);
    end
    chk("k1_done_cnt", 32'(b_done), 1);
    chk("k1_busy_end", 32'(b_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
